// File: rtl/conv_pool_sched_if.sv
// Handshake and status bundle between a frame source and the conv/pool scheduler.
interface conv_pool_sched_if;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic        conv_en;
   logic        pool_en;
   logic        row_last;
   logic        busy;
   logic        done;
   logic [15:0] stall_cnt;

   modport master (
      output start, in_valid,
      input  in_ready, conv_en, pool_en, row_last, busy, done, stall_cnt
   );

   modport slave (
      input  start, in_valid,
      output in_ready, conv_en, pool_en, row_last, busy, done, stall_cnt
   );
endinterface

// File: rtl/conv_pool_sched.sv
// Frame scheduler for a KxK convolution followed by POOLxPOOL pooling.
// Optional stall counter is enabled by defining CONV_POOL_SCHED_STALL_CNT_EN.
module conv_pool_sched #(
   parameter int IMG_W    = 32,
   parameter int IMG_H    = 32,
   parameter int K        = 5,
   parameter int POOL     = 2,
   parameter int PIPE_LAT = 4
) (
   input  logic             clk,
   input  logic             rst,
   conv_pool_sched_if.slave bus
);
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int PW = (POOL > 1) ? $clog2(POOL) : 1;
   localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_START  = CW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_START  = RW'(K - 1);
   localparam logic [PW-1:0] PH_MAX     = PW'(POOL - 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(PIPE_LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [PW-1:0] cph_q, cph_d;
   logic [PW-1:0] rph_q, rph_d;
   logic [FW-1:0] flush_q, flush_d;
   logic          conv_en_q, conv_en_d;
   logic          pool_en_q, pool_en_d;
   logic          row_last_q, row_last_d;

   logic transfer;
   logic col_end;
   logic row_end;
   logic conv_hit;
   logic start_run;
   logic in_ready;
   logic busy;
   logic done;

   assign start_run = (state_q == S_IDLE) & bus.start;
   assign transfer  = (state_q == S_RUN) & bus.in_valid;
   assign col_end   = (col_q == COL_LAST);
   assign row_end   = (row_q == ROW_LAST);
   assign conv_hit  = transfer & (row_q >= ROW_START) & (col_q >= COL_START);

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_RUN;
         S_RUN:   if (transfer && col_end && row_end) state_d = S_FLUSH;
         S_FLUSH: if (flush_q == FLUSH_LAST) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs decoded straight from state
   always_comb begin
      in_ready = (state_q == S_RUN);
      busy     = (state_q != S_IDLE);
      done     = (state_q == S_DONE);
   end

   // Pixel position and pool phase tracking; everything holds when no pixel moves
   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      cph_d      = cph_q;
      rph_d      = rph_q;
      flush_d    = '0;
      conv_en_d  = conv_hit;
      pool_en_d  = conv_hit & (cph_q == PH_MAX) & (rph_q == PH_MAX);
      row_last_d = conv_hit & col_end;

      if (state_q == S_FLUSH && flush_q != FLUSH_LAST) begin
         flush_d = flush_q + 1'b1;
      end

      if (start_run) begin
         col_d = '0;
         row_d = '0;
         cph_d = '0;
         rph_d = '0;
      end else if (transfer) begin
         if (col_end) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + 1'b1;
            // column phase restarts each row so a partial window never fires
            cph_d = '0;
            if (row_q >= ROW_START) begin
               rph_d = (rph_q == PH_MAX) ? '0 : rph_q + 1'b1;
            end
         end else begin
            col_d = col_q + 1'b1;
            if (conv_hit) begin
               cph_d = (cph_q == PH_MAX) ? '0 : cph_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q      <= '0;
         row_q      <= '0;
         cph_q      <= '0;
         rph_q      <= '0;
         flush_q    <= '0;
         conv_en_q  <= 1'b0;
         pool_en_q  <= 1'b0;
         row_last_q <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         cph_q      <= cph_d;
         rph_q      <= rph_d;
         flush_q    <= flush_d;
         conv_en_q  <= conv_en_d;
         pool_en_q  <= pool_en_d;
         row_last_q <= row_last_d;
      end
   end

`ifdef CONV_POOL_SCHED_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (start_run) begin
         stall_d = '0;
      end else if (state_q == S_RUN && !bus.in_valid && stall_q != 16'hFFFF) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign bus.stall_cnt = stall_q;
`else
   assign bus.stall_cnt = 16'h0000;
`endif

   assign bus.in_ready = in_ready;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.conv_en  = conv_en_q;
   assign bus.pool_en  = pool_en_q;
   assign bus.row_last = row_last_q;
endmodule
